// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU classes,
// hazard sequencer states and the control bundle carried into EX.
package id_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_BR  = 2'b01,
      ALU_R   = 2'b10
   } alu_op_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_to_reg;
      logic    mem_read;
      logic    mem_write;
      logic    alu_src;
      alu_op_e alu_op;
   } ex_ctrl_t;

   typedef struct packed {
      ex_ctrl_t ex;
      logic     is_beq;
      logic     is_bne;
      logic     is_j;
      logic     use_rs;
      logic     use_rt;
      logic     dest_rd;
      logic     dest_rt;
   } dec_t;

   // Unknown opcodes fall through with every field cleared, i.e. a NOP.
   function automatic dec_t decode(input logic [5:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_R: begin
            d.ex.reg_write = 1'b1;
            d.ex.alu_op    = ALU_R;
            d.use_rs       = 1'b1;
            d.use_rt       = 1'b1;
            d.dest_rd      = 1'b1;
         end
         OP_LW: begin
            d.ex.reg_write  = 1'b1;
            d.ex.mem_to_reg = 1'b1;
            d.ex.mem_read   = 1'b1;
            d.ex.alu_src    = 1'b1;
            d.ex.alu_op     = ALU_ADD;
            d.use_rs        = 1'b1;
            d.dest_rt       = 1'b1;
         end
         OP_SW: begin
            d.ex.mem_write = 1'b1;
            d.ex.alu_src   = 1'b1;
            d.ex.alu_op    = ALU_ADD;
            d.use_rs       = 1'b1;
            d.use_rt       = 1'b1;
         end
         OP_ADDI: begin
            d.ex.reg_write = 1'b1;
            d.ex.alu_src   = 1'b1;
            d.ex.alu_op    = ALU_ADD;
            d.use_rs       = 1'b1;
            d.dest_rt      = 1'b1;
         end
         OP_BEQ: begin
            d.ex.alu_op = ALU_BR;
            d.is_beq    = 1'b1;
            d.use_rs    = 1'b1;
            d.use_rt    = 1'b1;
         end
         OP_BNE: begin
            d.ex.alu_op = ALU_BR;
            d.is_bne    = 1'b1;
            d.use_rs    = 1'b1;
            d.use_rt    = 1'b1;
         end
         OP_J:    d.is_j = 1'b1;
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with two combinational read ports; a same-cycle write to a
// matching non-zero index is bypassed onto the read data. Index 0 reads zero.
module id_regfile #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_REGS       = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we,
   input  logic [REG_ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [REG_ADDR_WIDTH-1:0] raddr1,
   input  logic [REG_ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0]     rdata1,
   output logic [DATA_WIDTH-1:0]     rdata2
);

   logic [DATA_WIDTH-1:0]               regs [NUM_REGS];
   logic [1:0][REG_ADDR_WIDTH-1:0]      raddr;
   logic [1:0][DATA_WIDTH-1:0]          rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   assign raddr[0] = raddr1;
   assign raddr[1] = raddr2;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      assign rdata[p] = (raddr[p] == '0)               ? '0    :
                        (we && waddr == raddr[p])      ? wdata :
                                                         regs[raddr[p]];
   end

   assign rdata1 = rdata[0];
   assign rdata2 = rdata[1];

endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage: register file, main decoder, in-ID branch/jump resolution
// with EX/MEM forwarding, load-use/branch hazard sequencer and ID/EX register.
module id_stage_pipelined
   import id_pkg::*;
#(
   parameter int PC_WIDTH       = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_REGS       = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      if_id_valid,
   input  logic [PC_WIDTH-1:0]       pc_plus4,
   input  logic [31:0]               instr,
   input  logic                      mem_wb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] mem_wb_write_reg_addr,
   input  logic [DATA_WIDTH-1:0]     mem_wb_write_back_data,
   input  logic                      ex_mem_reg_write,
   input  logic                      ex_mem_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_mem_write_reg_addr,
   input  logic [DATA_WIDTH-1:0]     ex_mem_alu_result,
   input  logic                      ex_hold,
   input  logic                      kill,
   output logic                      stall_if,
   output logic                      flush_if,
   output logic                      branch_taken,
   output logic                      jump,
   output logic [PC_WIDTH-1:0]       branch_address,
   output logic [PC_WIDTH-1:0]       jump_address,
   output logic                      id_ex_valid,
   output logic                      id_ex_mem_to_reg,
   output logic                      id_ex_mem_read,
   output logic                      id_ex_mem_write,
   output logic                      id_ex_alu_src,
   output logic                      id_ex_reg_write,
   output logic [1:0]                id_ex_alu_op,
   output logic [DATA_WIDTH-1:0]     id_ex_reg1,
   output logic [DATA_WIDTH-1:0]     id_ex_reg2,
   output logic [DATA_WIDTH-1:0]     id_ex_imm,
   output logic [REG_ADDR_WIDTH-1:0] id_ex_rs,
   output logic [REG_ADDR_WIDTH-1:0] id_ex_rt,
   output logic [REG_ADDR_WIDTH-1:0] id_ex_dest
);

   typedef struct packed {
      logic                      valid;
      ex_ctrl_t                  ctrl;
      logic [DATA_WIDTH-1:0]     reg1;
      logic [DATA_WIDTH-1:0]     reg2;
      logic [DATA_WIDTH-1:0]     imm;
      logic [REG_ADDR_WIDTH-1:0] rs;
      logic [REG_ADDR_WIDTH-1:0] rt;
      logic [REG_ADDR_WIDTH-1:0] dest;
   } id_ex_t;

   logic [5:0]                opcode;
   logic [REG_ADDR_WIDTH-1:0] rs, rt, rd, dest;
   logic [DATA_WIDTH-1:0]     imm, rf_rs, rf_rt, op_a, op_b;
   dec_t                      dec;
   logic                      active, is_branch, eq, go;
   logic                      h1, h2, h3, hazard, bubble;
   state_e                    state, state_nx;
   id_ex_t                    id_ex, id_ex_nx;

   assign opcode = instr[31:26];
   assign rs     = REG_ADDR_WIDTH'(instr[25:21]);
   assign rt     = REG_ADDR_WIDTH'(instr[20:16]);
   assign rd     = REG_ADDR_WIDTH'(instr[15:11]);
   assign imm    = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
   assign dec    = decode(opcode);
   assign dest   = dec.dest_rd ? rd : (dec.dest_rt ? rt : '0);

   id_regfile #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_REGS       (NUM_REGS)
   ) u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (mem_wb_reg_write),
      .waddr  (mem_wb_write_reg_addr),
      .wdata  (mem_wb_write_back_data),
      .raddr1 (rs),
      .raddr2 (rt),
      .rdata1 (rf_rs),
      .rdata2 (rf_rt)
   );

   // EX/MEM ALU results beat the MEM/WB bypass already folded into rf_*.
   // Loads in EX/MEM are not forwardable here; H3 stalls them out instead.
   always_comb begin
      op_a = rf_rs;
      op_b = rf_rt;
      if (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_write_reg_addr != '0) begin
         if (ex_mem_write_reg_addr == rs) op_a = ex_mem_alu_result;
         if (ex_mem_write_reg_addr == rt) op_b = ex_mem_alu_result;
      end
   end

   assign eq        = (op_a == op_b);
   assign active    = if_id_valid & ~kill;
   assign is_branch = dec.is_beq | dec.is_bne;

   assign h1 = id_ex.ctrl.mem_read & (id_ex.dest != '0) &
               ((dec.use_rs & (id_ex.dest == rs)) | (dec.use_rt & (id_ex.dest == rt)));
   assign h2 = is_branch & id_ex.ctrl.reg_write & (id_ex.dest != '0) &
               ((id_ex.dest == rs) | (id_ex.dest == rt));
   assign h3 = is_branch & ex_mem_mem_read & (ex_mem_write_reg_addr != '0) &
               ((ex_mem_write_reg_addr == rs) | (ex_mem_write_reg_addr == rt));
   assign hazard = active & (h1 | h2 | h3);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nx;
   end

   // Stall is raised in the same cycle the hazard is seen so the dependent
   // instruction never leaves ID; the state records that a stall is in progress.
   always_comb begin
      state_nx = state;
      stall_if = 1'b0;
      if (reset) begin
         state_nx = ST_RUN;
      end else if (ex_hold) begin
         stall_if = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (hazard) begin
                  state_nx = ST_STALL;
                  stall_if = 1'b1;
               end
            end
            ST_STALL: begin
               if (hazard) stall_if = 1'b1;
               else        state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
         endcase
      end
   end

   assign go             = ~reset & active & ~stall_if;
   assign branch_taken   = go & ((dec.is_beq & eq) | (dec.is_bne & ~eq));
   assign jump           = go & dec.is_j;
   assign flush_if       = branch_taken | jump;
   assign branch_address = pc_plus4 + {imm[PC_WIDTH-3:0], 2'b00};
   assign jump_address   = {instr[PC_WIDTH-3:0], 2'b00};

   assign bubble = ~active | hazard;

   always_comb begin
      id_ex_nx.valid = 1'b1;
      id_ex_nx.ctrl  = dec.ex;
      id_ex_nx.reg1  = rf_rs;
      id_ex_nx.reg2  = rf_rt;
      id_ex_nx.imm   = imm;
      id_ex_nx.rs    = rs;
      id_ex_nx.rt    = rt;
      id_ex_nx.dest  = dest;
      if (bubble) begin
         id_ex_nx.valid = 1'b0;
         id_ex_nx.ctrl  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)         id_ex <= '0;
      else if (!ex_hold) id_ex <= id_ex_nx;
   end

   assign id_ex_valid      = id_ex.valid;
   assign id_ex_mem_to_reg = id_ex.ctrl.mem_to_reg;
   assign id_ex_mem_read   = id_ex.ctrl.mem_read;
   assign id_ex_mem_write  = id_ex.ctrl.mem_write;
   assign id_ex_alu_src    = id_ex.ctrl.alu_src;
   assign id_ex_reg_write  = id_ex.ctrl.reg_write;
   assign id_ex_alu_op     = id_ex.ctrl.alu_op;
   assign id_ex_reg1       = id_ex.reg1;
   assign id_ex_reg2       = id_ex.reg2;
   assign id_ex_imm        = id_ex.imm;
   assign id_ex_rs         = id_ex.rs;
   assign id_ex_rt         = id_ex.rt;
   assign id_ex_dest       = id_ex.dest;

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Second-generation decode stage for the 5-stage MIPS-subset core. Width-parametrised. Owns the register file, the main decoder, the ID/EX pipeline register and load-use/branch hazard detection with its own stall sequencer. Resolves BEQ/BNE and J in ID, using operands forwarded from EX/MEM and MEM/WB. Sits between the IF/ID register and the EX stage.

Parameters:
PC_WIDTH, 10, width of PC, branch and jump addresses
DATA_WIDTH, 32, register and immediate width
REG_ADDR_WIDTH, 5, register index width
NUM_REGS, 32, register count; reg 0 reads as zero

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
if_id_valid  in  1  IF/ID holds a real instruction
pc_plus4  in  PC_WIDTH  PC+4 of the instruction in ID
instr  in  32  instruction in ID
mem_wb_reg_write / mem_wb_write_reg_addr / mem_wb_write_back_data  in  1/REG_ADDR_WIDTH/DATA_WIDTH  register-file write port
ex_mem_reg_write / ex_mem_mem_read / ex_mem_write_reg_addr / ex_mem_alu_result  in  1/1/REG_ADDR_WIDTH/DATA_WIDTH  EX/MEM state, used for branch forwarding and hazards
ex_hold  in  1  downstream back-pressure: freeze ID/EX
kill  in  1  external squash of the ID instruction
stall_if  out  1  hold PC and IF/ID
flush_if  out  1  squash IF/ID (redirect taken)
branch_taken, jump  out  1  redirect select (combinational)
branch_address, jump_address  out  PC_WIDTH  redirect targets
id_ex_valid, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src, id_ex_reg_write  out  1  registered controls
id_ex_alu_op  out  2  registered ALU class
id_ex_reg1, id_ex_reg2, id_ex_imm  out  DATA_WIDTH  registered operands and sign-extended immediate
id_ex_rs, id_ex_rt, id_ex_dest  out  REG_ADDR_WIDTH  registered indices for EX forwarding

Behaviour:
- Reset: all id_ex_* = 0, all registers = 0, FSM = RUN. stall_if, flush_if, branch_taken and jump = 0 during reset.
- Register file: write on clk when mem_wb_reg_write and addr != 0. Reads are combinational with write-through bypass: a same-cycle write to a matching non-zero address is returned on the read.
- Decode: R 000000 (dest rd, alu_op 10); lw 100011 and sw 101011 (alu_op 00, alu_src 1); addi 001000 (dest rt, alu_op 00); beq 000100 and bne 000101 (alu_op 01); j 000010. Unknown opcodes decode as NOP (all controls 0).
- Branch operands: priority order is
  1. ex_mem_alu_result, when ex_mem_reg_write, !ex_mem_mem_read and the address matches a non-zero index;
  2. the MEM/WB bypass;
  3. the register file.
- branch_taken = go & (beq ? eq : bne ? !eq : 0). go = if_id_valid & !kill & !stall_if.
- branch_address = pc_plus4 + (imm << 2), truncated to PC_WIDTH, wrapping. jump_address = {instr[25:0], 2'b00} truncated to PC_WIDTH. jump = go & is_j.
- flush_if = branch_taken | jump.
- Hazard conditions (dest != 0 throughout):
  - H1: id_ex load whose dest matches rs, or rt when rt is a source.
  - H2: branch in ID, id_ex reg_write, and id_ex dest matches rs or rt.
  - H3: branch in ID, ex_mem_mem_read, and ex_mem dest matches rs or rt.
- FSM:
  - RUN: a hazard moves to STALL.
  - STALL: stall_if = 1 and a bubble is loaded into ID/EX (valid and all controls 0; data is don't-care). Stay in STALL while any hazard holds, otherwise return to RUN.
  - A branch that depends on a load in EX stalls exactly 2 cycles (H2, then H3). ALU→branch stalls 1 cycle. Load→ALU stalls 1 cycle.
- ex_hold has priority over everything: ID/EX holds its value, stall_if = 1, flush_if = 0, the FSM holds its state, and register-file writes still occur.
- kill or !if_id_valid: load a bubble, no redirect, no stall.
- Latency: decode to id_ex_* is 1 cycle. Redirect is in the same cycle.

Decomposition:
- Package id_pkg: opcode constants, alu_op encodings (ALU_ADD 00, ALU_BR 01, ALU_R 10), FSM state enum, control-bundle struct.
- One sub-module, id_regfile: parametrised register file with bypass.
- Decoder and hazard FSM stay inline.

Test Plan:
- Reset mid-stream with a lw in ID/EX → the next cycle all id_ex_* = 0, stall_if = 0, and r5 reads 0.
- lw r2,0(r1) then add r3,r2,r4 → stall_if high for 1 cycle, one bubble with id_ex_valid = 0, then the add issues with id_ex_rs = 2.
- lw r2 then beq r2,r0,+3 with pc_plus4 = 0x40 → 2 stall cycles, then branch_address = 0x4C, taken iff MEM/WB data = 0, and flush_if pulses for 1 cycle.
- addi r7,r0,5 then bne r7,r0 with the result forwarded from ex_mem → 1 stall, then branch_taken = 1 using forwarded 5.
- j 0x0FF with PC_WIDTH = 10 → jump = 1, jump_address = 0x3FC, flush_if = 1. Same instruction with kill = 1 → no redirect, bubble loaded.
- ex_hold for 3 cycles during a load-use stall → id_ex_* unchanged, the FSM stays in STALL, and a WB write to r9 is still visible afterwards.
